// File: rtl/interrupt_sequencer.sv
// 6502 interrupt/BRK/reset entry sequencer: NMI edge and IRQ level detection, arbitration at
// instruction boundaries, and the seven-step push / vector-fetch strobe sequence.
module interrupt_sequencer #(
    parameter int          NMI_SYNC_STAGES = 2,
    parameter logic [15:0] NMI_VEC         = 16'hFFFA,
    parameter logic [15:0] RES_VEC         = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC         = 16'hFFFE
) (
    input  logic        clk_1,
    input  logic        reset,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        rdy,
    input  logic        sync,
    input  logic        brk_op,
    input  logic        interrupt_flag,
    output logic        seq_active,
    output logic        force_brk,
    output logic [2:0]  step,
    output logic        push_pch,
    output logic        push_pcl,
    output logic        push_p,
    output logic        p_db,
    output logic        b_out_n,
    output logic        sp_dec,
    output logic        fetch_vec_lo,
    output logic        fetch_vec_hi,
    output logic [15:0] vector_addr,
    output logic        break_done,
    output logic        nmi_pending
);

    localparam int SYNC_N = (NMI_SYNC_STAGES < 2) ? 2 : NMI_SYNC_STAGES;

    localparam logic [2:0] STEP_T0   = 3'd0;
    localparam logic [2:0] STEP_T1   = 3'd1;
    localparam logic [2:0] STEP_T2   = 3'd2;
    localparam logic [2:0] STEP_T3   = 3'd3;
    localparam logic [2:0] STEP_T4   = 3'd4;
    localparam logic [2:0] STEP_T5   = 3'd5;
    localparam logic [2:0] STEP_T6   = 3'd6;
    localparam logic [2:0] STEP_IDLE = 3'd7;

    logic [SYNC_N-1:0] nmi_sync;
    logic [SYNC_N-1:0] irq_sync;
    logic              nmi_prev;
    logic              nmi_latch;
    logic              res_pend;
    logic              nmi_taken;
    logic              brk_seq;
    logic [2:0]        step_q;
    logic [2:0]        step_d;
    logic [15:0]       vec_q;

    logic nmi_s;
    logic irq_s;
    logic nmi_fall;
    logic irq_pend;
    logic idle;
    logic start_res;
    logic start_hw;
    logic start_brk;
    logic start_any;
    logic last_step;
    logic nmi_clear;

    // Both pins are asynchronous; the chains idle high so a reset never looks like an edge.
    always_ff @(posedge clk_1 or posedge reset) begin
        if (reset) begin
            nmi_sync <= '1;
            irq_sync <= '1;
            nmi_prev <= 1'b1;
        end else begin
            nmi_sync <= {nmi_sync[SYNC_N-2:0], nmi_n};
            irq_sync <= {irq_sync[SYNC_N-2:0], irq_n};
            nmi_prev <= nmi_s;
        end
    end

    assign nmi_s    = nmi_sync[SYNC_N-1];
    assign irq_s    = irq_sync[SYNC_N-1];
    assign nmi_fall = nmi_prev & ~nmi_s;
    assign irq_pend = ~irq_s & ~interrupt_flag;

    // rdy is a stall-only qualifier: while low the step is frozen and every strobe is masked,
    // and the same step replays its strobes on the first cycle rdy is high again.
    assign idle      = (step_q == STEP_IDLE);
    assign start_res = idle & rdy & res_pend;
    assign start_hw  = idle & rdy & sync & ~res_pend & (nmi_latch | irq_pend);
    assign start_brk = idle & rdy & sync & ~res_pend & ~nmi_latch & ~irq_pend & brk_op;
    assign start_any = start_res | start_hw | start_brk;
    assign last_step = (step_q == STEP_T6) & rdy;
    assign nmi_clear = fetch_vec_lo & nmi_taken;

    always_comb begin
        step_d = step_q;
        if (start_any) begin
            step_d = STEP_T0;
        end else if (!idle && rdy) begin
            step_d = (step_q == STEP_T6) ? STEP_IDLE : step_q + 3'd1;
        end
    end

    always_ff @(posedge clk_1 or posedge reset) begin
        if (reset) begin
            step_q    <= STEP_IDLE;
            res_pend  <= 1'b1;
            brk_seq   <= 1'b0;
            nmi_latch <= 1'b0;
            nmi_taken <= 1'b0;
            vec_q     <= RES_VEC;
        end else begin
            step_q <= step_d;

            if (start_brk) begin
                brk_seq <= 1'b1;
            end else if (start_res || start_hw || last_step) begin
                brk_seq <= 1'b0;
            end

            if (last_step) begin
                res_pend <= 1'b0;
            end

            // A fresh edge in the clearing cycle must not be lost, so set has priority.
            nmi_latch <= nmi_fall | (nmi_latch & ~nmi_clear);

            // The vector is chosen at T4 so a late NMI can still hijack a BRK or IRQ entry.
            if ((step_q == STEP_T4) && rdy) begin
                if (res_pend) begin
                    vec_q <= RES_VEC;
                end else if (nmi_latch) begin
                    vec_q <= NMI_VEC;
                end else begin
                    vec_q <= IRQ_VEC;
                end
                nmi_taken <= ~res_pend & nmi_latch;
            end else if (last_step) begin
                nmi_taken <= 1'b0;
            end
        end
    end

    always_comb begin
        push_pch     = 1'b0;
        push_pcl     = 1'b0;
        push_p       = 1'b0;
        sp_dec       = 1'b0;
        fetch_vec_lo = 1'b0;
        fetch_vec_hi = 1'b0;
        break_done   = 1'b0;
        if (rdy) begin
            case (step_q)
                STEP_T2: begin
                    push_pch = ~res_pend;
                    sp_dec   = 1'b1;
                end
                STEP_T3: begin
                    push_pcl = ~res_pend;
                    sp_dec   = 1'b1;
                end
                STEP_T4: begin
                    push_p = ~res_pend;
                    sp_dec = 1'b1;
                end
                STEP_T5: fetch_vec_lo = 1'b1;
                STEP_T6: begin
                    fetch_vec_hi = 1'b1;
                    break_done   = 1'b1;
                end
                STEP_T0, STEP_T1, STEP_IDLE: ;
                default: ;
            endcase
        end
    end

    assign step        = step_q;
    assign seq_active  = ~idle;
    assign force_brk   = (step_q == STEP_T0) & ~brk_seq;
    assign p_db        = push_p;
    assign b_out_n     = brk_seq;
    assign vector_addr = vec_q;
    assign nmi_pending = nmi_latch;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scenario bench for interrupt_sequencer: per-cycle expected output words are queued when a
// sequence is launched and popped as each cycle is observed.
module tb_interrupt_sequencer;

    localparam int W     = 30;
    localparam int K_RES = 0;
    localparam int K_HW  = 1;
    localparam int K_BRK = 2;

    logic        clk_1;
    logic        reset;
    logic        nmi_n;
    logic        irq_n;
    logic        rdy;
    logic        sync;
    logic        brk_op;
    logic        interrupt_flag;
    logic        seq_active;
    logic        force_brk;
    logic [2:0]  step;
    logic        push_pch;
    logic        push_pcl;
    logic        push_p;
    logic        p_db;
    logic        b_out_n;
    logic        sp_dec;
    logic        fetch_vec_lo;
    logic        fetch_vec_hi;
    logic [15:0] vector_addr;
    logic        break_done;
    logic        nmi_pending;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs;
    logic [W-1:0] got;
    logic [W-1:0] want;
    logic [15:0]  prev_vec;
    int           checks;
    int           errors;

    interrupt_sequencer dut (
        .clk_1         (clk_1),
        .reset         (reset),
        .nmi_n         (nmi_n),
        .irq_n         (irq_n),
        .rdy           (rdy),
        .sync          (sync),
        .brk_op        (brk_op),
        .interrupt_flag(interrupt_flag),
        .seq_active    (seq_active),
        .force_brk     (force_brk),
        .step          (step),
        .push_pch      (push_pch),
        .push_pcl      (push_pcl),
        .push_p        (push_p),
        .p_db          (p_db),
        .b_out_n       (b_out_n),
        .sp_dec        (sp_dec),
        .fetch_vec_lo  (fetch_vec_lo),
        .fetch_vec_hi  (fetch_vec_hi),
        .vector_addr   (vector_addr),
        .break_done    (break_done),
        .nmi_pending   (nmi_pending)
    );

    assign obs = {step, seq_active, force_brk, push_pch, push_pcl, push_p, p_db, sp_dec,
                  fetch_vec_lo, fetch_vec_hi, break_done, b_out_n, vector_addr};

    initial begin
        clk_1 = 1'b0;
        forever #5 clk_1 = ~clk_1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Expected outputs for one observed cycle, built from the step table.
    function automatic logic [W-1:0] exp_word(input logic [2:0] s, input logic r, input int kind,
                                              input logic [15:0] v);
        logic push_ok;
        logic act, fb, pch, pcl, pp, spd, flo, fhi, bo;
        push_ok = (kind != K_RES) && r;
        act = (s != 3'd7);
        fb  = (s == 3'd0) && (kind != K_BRK);
        pch = push_ok && (s == 3'd2);
        pcl = push_ok && (s == 3'd3);
        pp  = push_ok && (s == 3'd4);
        spd = r && ((s == 3'd2) || (s == 3'd3) || (s == 3'd4));
        flo = r && (s == 3'd5);
        fhi = r && (s == 3'd6);
        bo  = (s != 3'd7) && (kind == K_BRK);
        return {s, act, fb, pch, pcl, pp, pp, spd, flo, fhi, fhi, bo, v};
    endfunction

    task automatic push_seq(input int kind, input logic [15:0] vec, input int stall_step,
                            input int stall_len, input int last_step);
        logic [15:0] v;
        for (int s = 0; s <= last_step; s++) begin
            v = (s >= 5) ? vec : prev_vec;
            if (s == stall_step) begin
                for (int k = 0; k < stall_len; k++) exp_q.push_back(exp_word(3'(s), 1'b0, kind, v));
            end
            exp_q.push_back(exp_word(3'(s), 1'b1, kind, v));
        end
        if (last_step == 6) begin
            exp_q.push_back(exp_word(3'd7, 1'b1, kind, vec));
            prev_vec = vec;
        end
    endtask

    task automatic launch(input logic is_brk);
        @(posedge clk_1);
        #1;
        sync   = 1'b1;
        brk_op = is_brk;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk_1);
        @(negedge clk_1);
        got  = obs;
        want = exp_word(3'd7, 1'b1, K_RES, 16'hFFFC);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_idle: got %h want %h", got, want);
        end
        checks++;
        if (nmi_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_nmi_pending: got %b want 0", nmi_pending);
        end
        prev_vec = 16'hFFFC;
        push_seq(K_RES, 16'hFFFC, -1, 0, 6);
        @(posedge clk_1);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_1);
            @(negedge clk_1);
            got  = obs;
            want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_seq[%0d]: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_irq();
        @(posedge clk_1);
        #1;
        irq_n          = 1'b0;
        interrupt_flag = 1'b0;
        repeat (2) @(posedge clk_1);
        push_seq(K_HW, 16'hFFFE, -1, 0, 6);
        launch(1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_1);
            #1;
            sync = 1'b0;
            if (i == 1) irq_n = 1'b1;
            @(negedge clk_1);
            got  = obs;
            want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL irq_seq[%0d]: got %h want %h", i, got, want);
            end
        end
        // Masked IRQ at a boundary must leave the sequencer idle.
        @(posedge clk_1);
        #1;
        irq_n          = 1'b0;
        interrupt_flag = 1'b1;
        repeat (2) @(posedge clk_1);
        exp_q.push_back(exp_word(3'd7, 1'b1, K_HW, prev_vec));
        exp_q.push_back(exp_word(3'd7, 1'b1, K_HW, prev_vec));
        launch(1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_1);
            #1;
            sync = 1'b0;
            @(negedge clk_1);
            got  = obs;
            want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL irq_masked[%0d]: got %h want %h", i, got, want);
            end
        end
        @(posedge clk_1);
        #1;
        irq_n          = 1'b1;
        interrupt_flag = 1'b0;
        repeat (3) @(posedge clk_1);
    endtask

    task automatic test_nmi_hijack();
        logic exp_pend;
        push_seq(K_BRK, 16'hFFFA, -1, 0, 6);
        launch(1'b1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_1);
            #1;
            sync   = 1'b0;
            brk_op = 1'b0;
            if (i == 1) nmi_n = 1'b0;
            if (i == 6) nmi_n = 1'b1;
            @(negedge clk_1);
            got  = obs;
            want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL brk_hijack[%0d]: got %h want %h", i, got, want);
            end
            exp_pend = (i == 4) || (i == 5);
            checks++;
            if (nmi_pending !== exp_pend) begin
                errors++;
                $display("FAIL hijack_pending[%0d]: got %b want %b", i, nmi_pending, exp_pend);
            end
        end
    endtask

    task automatic test_nmi_late();
        @(posedge clk_1);
        #1;
        irq_n = 1'b0;
        repeat (2) @(posedge clk_1);
        push_seq(K_HW, 16'hFFFE, -1, 0, 6);
        launch(1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_1);
            #1;
            sync = 1'b0;
            if (i == 1) irq_n = 1'b1;
            if (i == 5) nmi_n = 1'b0;
            @(negedge clk_1);
            got  = obs;
            want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL late_nmi_irq[%0d]: got %h want %h", i, got, want);
            end
        end
        @(posedge clk_1);
        #1;
        nmi_n = 1'b1;
        @(negedge clk_1);
        checks++;
        if (nmi_pending !== 1'b1) begin
            errors++;
            $display("FAIL late_nmi_pending: got %b want 1", nmi_pending);
        end
        push_seq(K_HW, 16'hFFFA, -1, 0, 6);
        launch(1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_1);
            #1;
            sync = 1'b0;
            @(negedge clk_1);
            got  = obs;
            want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL late_nmi_seq[%0d]: got %h want %h", i, got, want);
            end
        end
        checks++;
        if (nmi_pending !== 1'b0) begin
            errors++;
            $display("FAIL late_nmi_cleared: got %b want 0", nmi_pending);
        end
    endtask

    task automatic test_stall();
        push_seq(K_BRK, 16'hFFFE, 3, 3, 6);
        launch(1'b1);
        for (int i = 0; i < 11; i++) begin
            @(posedge clk_1);
            #1;
            rdy    = !((i >= 3) && (i <= 5));
            sync   = (i == 2);
            brk_op = (i == 2);
            @(negedge clk_1);
            got  = obs;
            want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL stall_seq[%0d]: got %h want %h", i, got, want);
            end
        end
        rdy = 1'b1;
    endtask

    task automatic test_reset_abort();
        @(posedge clk_1);
        #1;
        nmi_n = 1'b0;
        repeat (3) @(posedge clk_1);
        @(negedge clk_1);
        checks++;
        if (nmi_pending !== 1'b1) begin
            errors++;
            $display("FAIL abort_nmi_latched: got %b want 1", nmi_pending);
        end
        push_seq(K_HW, 16'hFFFA, -1, 0, 4);
        launch(1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_1);
            #1;
            sync  = 1'b0;
            nmi_n = 1'b1;
            @(negedge clk_1);
            got  = obs;
            want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL abort_nmi_seq[%0d]: got %h want %h", i, got, want);
            end
        end
        reset = 1'b1;
        #1;
        got  = obs;
        want = exp_word(3'd7, 1'b1, K_RES, 16'hFFFC);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL abort_async_clear: got %h want %h", got, want);
        end
        checks++;
        if (nmi_pending !== 1'b0) begin
            errors++;
            $display("FAIL abort_nmi_pending: got %b want 0", nmi_pending);
        end
        prev_vec = 16'hFFFC;
        push_seq(K_RES, 16'hFFFC, -1, 0, 6);
        repeat (2) @(posedge clk_1);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_1);
            @(negedge clk_1);
            got  = obs;
            want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL abort_reset_seq[%0d]: got %h want %h", i, got, want);
            end
        end
        checks++;
        if (nmi_pending !== 1'b0) begin
            errors++;
            $display("FAIL abort_final_pending: got %b want 0", nmi_pending);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        prev_vec       = 16'hFFFC;
        reset          = 1'b1;
        nmi_n          = 1'b1;
        irq_n          = 1'b1;
        rdy            = 1'b1;
        sync           = 1'b0;
        brk_op         = 1'b0;
        interrupt_flag = 1'b0;

        test_reset();
        test_irq();
        test_nmi_hijack();
        test_nmi_late();
        test_stall();
        test_reset_abort();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
